rpm_multi: RTL

RPM_MULTI -- requirements
Module: rpm_multi

---
 rtl/rpm_multi.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rpm_multi.sv
// rpm_multi: per-channel tachometer period meter with a DEPTH-sample moving average.
// Define RPM_DEBOUNCE_EN to add a stability filter between the synchronizer and the edge detector.
module rpm_multi #(
   parameter int WIDTH           = 16,
   parameter int DEPTH_LOG2      = 2,
   parameter int CHANNELS        = 4,
   parameter int STALL_LIMIT     = 65535,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       pulse,
   output logic [CHANNELS*WIDTH-1:0] period,
   output logic [CHANNELS-1:0]       valid,
   output logic [CHANNELS-1:0]       stalled,
   output logic [CHANNELS-1:0]       sample
);
   localparam int DEPTH  = 2**DEPTH_LOG2;
   localparam int SUM_W  = WIDTH + DEPTH_LOG2;
   localparam int FILL_W = DEPTH_LOG2 + 1;
   localparam logic [WIDTH-1:0]  LIMIT   = WIDTH'(STALL_LIMIT);
   localparam logic [WIDTH-1:0]  MAX_VAL = '1;
   localparam logic [FILL_W-1:0] FULL    = FILL_W'(DEPTH);

   typedef enum logic {DISARMED, ARMED} state_t;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic                  sync1_reg, sync2_reg;
         logic                  level, level_prev_reg, edge_det_reg;
         state_t                state_reg;
         logic [WIDTH-1:0]      timer_reg;
         logic [WIDTH-1:0]      slot_reg [DEPTH];
         logic [DEPTH_LOG2-1:0] idx_reg;
         logic [SUM_W-1:0]      sum_reg;
         logic [FILL_W-1:0]     fill_reg;
         logic [WIDTH-1:0]      period_reg;
         logic                  valid_reg, stalled_reg, sample_reg;
         logic [WIDTH-1:0]      elapsed;
         logic [WIDTH-1:0]      average;

         always_ff @(posedge clk) begin
            if (reset) begin
               sync1_reg      <= 1'b0;
               sync2_reg      <= 1'b0;
               level_prev_reg <= 1'b0;
               edge_det_reg   <= 1'b0;
            end else begin
               sync1_reg      <= pulse[gi];
               sync2_reg      <= sync1_reg;
               level_prev_reg <= level;
               edge_det_reg   <= level & ~level_prev_reg;
            end
         end

`ifdef RPM_DEBOUNCE_EN
         localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
         logic             deb_level_reg;
         logic [CNT_W-1:0] deb_cnt_reg;

         // A new level is adopted only after it has differed from the held level for DEBOUNCE_CYCLES cycles in a row.
         always_ff @(posedge clk) begin
            if (reset) begin
               deb_level_reg <= 1'b0;
               deb_cnt_reg   <= '0;
            end else if (sync2_reg != deb_level_reg) begin
               if (deb_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb_level_reg <= sync2_reg;
                  deb_cnt_reg   <= '0;
               end else begin
                  deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
               end
            end else begin
               deb_cnt_reg <= '0;
            end
         end
         assign level = deb_level_reg;
`else
         assign level = sync2_reg;
`endif

         // The stored sample includes the edge cycle itself, so edges N cycles apart measure N.
         assign elapsed = (timer_reg == MAX_VAL) ? MAX_VAL : timer_reg + WIDTH'(1);
         assign average = WIDTH'(sum_reg >> DEPTH_LOG2);

         always_ff @(posedge clk) begin
            if (reset) begin
               state_reg   <= DISARMED;
               timer_reg   <= '0;
               idx_reg     <= '0;
               sum_reg     <= '0;
               fill_reg    <= '0;
               period_reg  <= '0;
               valid_reg   <= 1'b0;
               stalled_reg <= 1'b0;
               sample_reg  <= 1'b0;
               for (int i = 0; i < DEPTH; i++) slot_reg[i] <= '0;
            end else begin
               sample_reg <= 1'b0;
               valid_reg  <= (fill_reg == FULL);
               period_reg <= (fill_reg == FULL) ? average : '0;
               if (timer_reg != LIMIT) timer_reg <= timer_reg + WIDTH'(1);

               if (edge_det_reg) begin
                  timer_reg <= '0;
                  if (state_reg == DISARMED) begin
                     state_reg   <= ARMED;
                     stalled_reg <= 1'b0;
                  end else begin
                     slot_reg[idx_reg] <= elapsed;
                     sum_reg    <= sum_reg - SUM_W'(slot_reg[idx_reg]) + SUM_W'(elapsed);
                     idx_reg    <= idx_reg + DEPTH_LOG2'(1);
                     if (fill_reg != FULL) fill_reg <= fill_reg + FILL_W'(1);
                     sample_reg <= 1'b1;
                  end
               end else if (state_reg == ARMED && timer_reg == LIMIT) begin
                  state_reg   <= DISARMED;
                  stalled_reg <= 1'b1;
                  valid_reg   <= 1'b0;
                  period_reg  <= '0;
                  sum_reg     <= '0;
                  fill_reg    <= '0;
                  idx_reg     <= '0;
                  for (int i = 0; i < DEPTH; i++) slot_reg[i] <= '0;
               end
            end
         end

         assign period[gi*WIDTH +: WIDTH] = period_reg;
         assign valid[gi]   = valid_reg;
         assign stalled[gi] = stalled_reg;
         assign sample[gi]  = sample_reg;
      end
   endgenerate
endmodule
